// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: per-channel edge/level latching, masking,
// fixed-priority arbitration and a vectored IRQ/IRQAck/EOI handshake to the CPU.
module irq_controller #(
  parameter int N_CHAN = 8,
  parameter int VEC_W  = 12
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [N_CHAN-1:0] irqIn,
  input  logic              cfgWrEn,
  input  logic [5:0]        cfgAddr,
  input  logic [31:0]       cfgWrData,
  output logic [31:0]       cfgRdData,
  output logic              IRQ,
  output logic [VEC_W-1:0]  IRQn,
  input  logic              IRQAck
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t             state_r;
  logic [4:0]         chan_r;
  logic               irq_r;
  logic [VEC_W-1:0]   irqn_r;
  logic [N_CHAN-1:0]  enable_r;
  logic [N_CHAN-1:0]  edge_r;
  logic [N_CHAN-1:0]  pending_r;
  logic [N_CHAN-1:0]  irq_prev_r;
  logic [VEC_W-1:0]   vector_r [N_CHAN];

  logic [N_CHAN-1:0]  cand_s;
  logic [N_CHAN-1:0]  grant_mask_s;
  logic [N_CHAN-1:0]  pending_next_s;
  logic               grant_valid_s;
  logic               grant_take_s;
  logic [4:0]         grant_chan_s;
  logic [VEC_W-1:0]   grant_vec_s;
  logic [VEC_W-1:0]   vec_rd_s;
  logic               wr_enable_s;
  logic               wr_edge_s;
  logic               wr_pending_s;
  logic               eoi_s;
  logic               unused_wdata;

  assign wr_enable_s  = cfgWrEn && (cfgAddr == 6'h00);
  assign wr_edge_s    = cfgWrEn && (cfgAddr == 6'h01);
  assign wr_pending_s = cfgWrEn && (cfgAddr == 6'h02);
  assign eoi_s        = cfgWrEn && (cfgAddr == 6'h04);
  assign cand_s       = pending_r & enable_r;
  assign grant_take_s = grant_valid_s && (state_r == ST_IDLE);
  assign unused_wdata = ^cfgWrData;

  assign IRQ  = irq_r;
  assign IRQn = irqn_r;

  // Fixed-priority pick: scanning downward lets the lowest-index candidate win.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_chan_s  = 5'd0;
    grant_vec_s   = {VEC_W{1'b0}};
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      grant_valid_s = cand_s[i] | grant_valid_s;
      grant_chan_s  = cand_s[i] ? 5'(i) : grant_chan_s;
      grant_vec_s   = cand_s[i] ? vector_r[i] : grant_vec_s;
    end
  end

  // One-hot of the channel being granted this edge, used to clear its edge latch.
  always_comb begin
    grant_mask_s = {N_CHAN{1'b0}};
    for (int i = 0; i < N_CHAN; i++) begin
      grant_mask_s[i] = grant_take_s && (grant_chan_s == 5'(i));
    end
  end

  // Next pending state: edge channels latch rises (set beats clear), level channels follow the line.
  always_comb begin
    pending_next_s = pending_r;
    for (int i = 0; i < N_CHAN; i++) begin
      if (edge_r[i]) begin
        pending_next_s[i] = (irqIn[i] & ~irq_prev_r[i]) |
                            (pending_r[i] & ~(wr_pending_s & cfgWrData[i]) & ~grant_mask_s[i]);
      end else begin
        pending_next_s[i] = irqIn[i];
      end
    end
  end

  // Vector readback for addresses 0x20+i; non-matching addresses leave it zero.
  always_comb begin
    vec_rd_s = {VEC_W{1'b0}};
    for (int i = 0; i < N_CHAN; i++) begin
      vec_rd_s = (cfgAddr == 6'(32 + i)) ? vector_r[i] : vec_rd_s;
    end
  end

  // Register read mux.
  always_comb begin
    cfgRdData = 32'd0;
    case (cfgAddr)
      6'h00: cfgRdData[N_CHAN-1:0] = enable_r;
      6'h01: cfgRdData[N_CHAN-1:0] = edge_r;
      6'h02: cfgRdData[N_CHAN-1:0] = pending_r;
      6'h03: begin
        if (state_r == ST_SVC) begin
          cfgRdData[31]  = 1'b1;
          cfgRdData[4:0] = chan_r;
        end else begin
          cfgRdData = 32'd0;
        end
      end
      default: cfgRdData[VEC_W-1:0] = vec_rd_s;
    endcase
  end

  // Configuration, pending latches and input history.
  always_ff @(posedge clk) begin
    if (nRst) begin
      enable_r   <= {N_CHAN{1'b0}};
      edge_r     <= {N_CHAN{1'b0}};
      pending_r  <= {N_CHAN{1'b0}};
      irq_prev_r <= {N_CHAN{1'b0}};
      for (int i = 0; i < N_CHAN; i++) begin
        vector_r[i] <= {VEC_W{1'b0}};
      end
    end else begin
      irq_prev_r <= irqIn;
      pending_r  <= pending_next_s;
      if (wr_enable_s) begin
        enable_r <= cfgWrData[N_CHAN-1:0];
      end
      if (wr_edge_s) begin
        edge_r <= cfgWrData[N_CHAN-1:0];
      end
      for (int i = 0; i < N_CHAN; i++) begin
        if (cfgWrEn && (cfgAddr == 6'(32 + i))) begin
          vector_r[i] <= cfgWrData[VEC_W-1:0];
        end
      end
    end
  end

  // Request handshake FSM; channel and vector are frozen once granted.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_r <= ST_IDLE;
      chan_r  <= 5'd0;
      irq_r   <= 1'b0;
      irqn_r  <= {VEC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            chan_r  <= grant_chan_s;
            irqn_r  <= grant_vec_s;
            irq_r   <= 1'b1;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (IRQAck) begin
            irq_r   <= 1'b0;
            state_r <= ST_SVC;
          end
        end
        ST_SVC: begin
          if (eoi_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          irq_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized
// soak compared against a cycle-level behavioural model of the controller.
`timescale 1ns/1ps
module tb_irq_controller;

  logic        clk;
  logic        nRst;
  logic [7:0]  irqIn;
  logic        cfgWrEn;
  logic [5:0]  cfgAddr;
  logic [31:0] cfgWrData;
  logic [31:0] cfgRdData;
  logic        IRQ;
  logic [11:0] IRQn;
  logic        IRQAck;

  int checks;
  int failures;

  irq_controller #(.N_CHAN(8), .VEC_W(12)) dut (
    .clk(clk), .nRst(nRst), .irqIn(irqIn), .cfgWrEn(cfgWrEn), .cfgAddr(cfgAddr),
    .cfgWrData(cfgWrData), .cfgRdData(cfgRdData), .IRQ(IRQ), .IRQn(IRQn), .IRQAck(IRQAck)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Behavioural model: 0 = idle, 1 = requesting, 2 = in service
  bit          m_en[8];
  bit          m_edge[8];
  bit          m_pend[8];
  bit          m_prev[8];
  logic [11:0] m_vec[8];
  int          m_state;
  int          m_chan;
  bit          m_irq;
  logic [11:0] m_irqn;

  task automatic model_step();
    bit np[8];
    int grant;
    if (nRst) begin
      for (int i = 0; i < 8; i++) begin
        m_en[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_prev[i] = 0; m_vec[i] = 12'd0;
      end
      m_state = 0; m_chan = 0; m_irq = 0; m_irqn = 12'd0;
      return;
    end
    grant = -1;
    if (m_state == 0)
      for (int i = 0; i < 8; i++)
        if (grant < 0 && m_pend[i] && m_en[i]) grant = i;
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i])
        np[i] = (irqIn[i] && !m_prev[i]) ||
                (m_pend[i] && !(cfgWrEn && cfgAddr == 6'd2 && cfgWrData[i]) && grant != i);
      else
        np[i] = irqIn[i];
    end
    case (m_state)
      0: if (grant >= 0) begin m_chan = grant; m_irq = 1; m_irqn = m_vec[grant]; m_state = 1; end
      1: if (IRQAck) begin m_irq = 0; m_state = 2; end
      2: if (cfgWrEn && cfgAddr == 6'd4) m_state = 0;
      default: m_state = 0;
    endcase
    if (cfgWrEn) begin
      if (cfgAddr == 6'd0) for (int i = 0; i < 8; i++) m_en[i] = cfgWrData[i];
      if (cfgAddr == 6'd1) for (int i = 0; i < 8; i++) m_edge[i] = cfgWrData[i];
      if (cfgAddr >= 6'h20 && cfgAddr < 6'h28) m_vec[int'(cfgAddr) - 32] = cfgWrData[11:0];
    end
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = irqIn[i];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 6'd0) for (int i = 0; i < 8; i++) r[i] = m_en[i];
    else if (a == 6'd1) for (int i = 0; i < 8; i++) r[i] = m_edge[i];
    else if (a == 6'd2) for (int i = 0; i < 8; i++) r[i] = m_pend[i];
    else if (a == 6'd3 && m_state == 2) r = 32'h8000_0000 | 32'(m_chan);
    else if (a >= 6'h20 && a < 6'h28) r[11:0] = m_vec[int'(a) - 32];
    return r;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    cfgWrEn = 1'b1; cfgAddr = a; cfgWrData = d;
    cycle();
    cfgWrEn = 1'b0;
  endtask

  task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
    cfgWrEn = 1'b0; cfgAddr = a;
    #1;
    d = cfgRdData;
  endtask

  task automatic ack();
    IRQAck = 1'b1;
    cycle();
    IRQAck = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cfg_write(6'h00, 32'h01); cfg_write(6'h01, 32'h01); cfg_write(6'h20, 32'hABC);
    irqIn = 8'h01; cycle(); irqIn = 8'h00; cycle();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL reset_setup_irq: got %b want 1", IRQ); end
    nRst = 1'b1; cycle(); cycle(); nRst = 1'b0;
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    checks++; if (IRQn !== 12'h000) begin failures++; $display("FAIL reset_irqn: got %h want 000", IRQn); end
    for (int a = 0; a < 5; a++) begin
      cfg_read(6'(a), d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
    for (int a = 32; a < 40; a++) begin
      cfg_read(6'(a), d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_vec%0d: got %h want 0", a - 32, d); end
    end
  endtask

  task automatic test_single_edge();
    logic [31:0] d;
    cfg_write(6'h00, 32'h04); cfg_write(6'h01, 32'h04); cfg_write(6'h22, 32'h123);
    irqIn = 8'h04; cycle(); irqIn = 8'h00;
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL single_early_irq: got %b want 0", IRQ); end
    cycle();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL single_irq: got %b want 1", IRQ); end
    checks++; if (IRQn !== 12'h123) begin failures++; $display("FAIL single_irqn: got %h want 123", IRQn); end
    ack();
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL single_ack_irq: got %b want 0", IRQ); end
    cfg_read(6'h03, d);
    checks++; if (d !== 32'h8000_0002) begin failures++; $display("FAIL single_active: got %h want 80000002", d); end
    cfg_write(6'h04, 32'h0);
    cfg_read(6'h03, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL single_eoi_active: got %h want 0", d); end
    cfg_read(6'h02, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL single_eoi_pending: got %h want 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    cfg_write(6'h00, 32'hFF); cfg_write(6'h01, 32'hFF);
    cfg_write(6'h21, 32'h011); cfg_write(6'h25, 32'h055);
    irqIn = 8'h22; cycle(); irqIn = 8'h00; cycle();
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h011) begin failures++; $display("FAIL prio_first: got irq=%b vec=%h want 1/011", IRQ, IRQn); end
    cfg_read(6'h02, d);
    checks++; if (d !== 32'h20) begin failures++; $display("FAIL prio_pending: got %h want 20", d); end
    ack();
    cfg_read(6'h03, d);
    checks++; if (d !== 32'h8000_0001) begin failures++; $display("FAIL prio_active1: got %h want 80000001", d); end
    cfg_write(6'h04, 32'h0); cycle();
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h055) begin failures++; $display("FAIL prio_second: got irq=%b vec=%h want 1/055", IRQ, IRQn); end
    ack();
    cfg_read(6'h03, d);
    checks++; if (d !== 32'h8000_0005) begin failures++; $display("FAIL prio_active5: got %h want 80000005", d); end
    cfg_write(6'h04, 32'h0);
  endtask

  task automatic test_level();
    cfg_write(6'h01, 32'h00); cfg_write(6'h00, 32'h08); cfg_write(6'h23, 32'h333);
    irqIn = 8'h08; cycle(); cycle();
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h333) begin failures++; $display("FAIL level_first: got irq=%b vec=%h want 1/333", IRQ, IRQn); end
    ack(); cfg_write(6'h04, 32'h0); cycle();
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h333) begin failures++; $display("FAIL level_regrant: got irq=%b vec=%h want 1/333", IRQ, IRQn); end
    ack(); irqIn = 8'h00; cfg_write(6'h04, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL level_quiet%0d: got %b want 0", k, IRQ); end
    end
  endtask

  task automatic test_mask_w1c();
    logic [31:0] d;
    cfg_write(6'h00, 32'h00); cfg_write(6'h01, 32'h01);
    irqIn = 8'h01; cycle(); irqIn = 8'h00; cycle();
    cfg_read(6'h02, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mask_pending: got %h want 1", d); end
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL mask_irq: got %b want 0", IRQ); end
    cfg_write(6'h02, 32'h1);
    cfg_read(6'h02, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL w1c_pending: got %h want 0", d); end
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL w1c_irq: got %b want 0", IRQ); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    cfg_write(6'h00, 32'h00); cfg_write(6'h01, 32'h10); cfg_write(6'h24, 32'h444);
    irqIn = 8'h10; cycle(); irqIn = 8'h00; cycle();
    irqIn = 8'h10; cfg_write(6'h02, 32'h10); irqIn = 8'h00;
    cfg_read(6'h02, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL collide_pending: got %h want 10", d); end
    cfg_write(6'h00, 32'h10); cycle();
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h444) begin failures++; $display("FAIL collide_grant: got irq=%b vec=%h want 1/444", IRQ, IRQn); end
    cfg_write(6'h04, 32'h0);
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h444) begin failures++; $display("FAIL eoi_in_req: got irq=%b vec=%h want 1/444", IRQ, IRQn); end
    cfg_read(6'h03, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL eoi_in_req_active: got %h want 0", d); end
    ack();
    cfg_read(6'h03, d);
    checks++; if (d !== 32'h8000_0004) begin failures++; $display("FAIL collide_active: got %h want 80000004", d); end
    cfg_write(6'h04, 32'h0);
  endtask

  task automatic test_regrant();
    logic [31:0] d;
    cfg_write(6'h00, 32'h00); cfg_write(6'h01, 32'h40); cfg_write(6'h26, 32'h666);
    irqIn = 8'h40; cycle(); irqIn = 8'h00;
    cfg_write(6'h00, 32'h40);
    irqIn = 8'h40; cycle(); irqIn = 8'h00;
    checks++; if (IRQ !== 1'b1 || IRQn !== 12'h666) begin failures++; $display("FAIL regrant_first: got irq=%b vec=%h want 1/666", IRQ, IRQn); end
    cfg_read(6'h02, d);
    checks++; if (d !== 32'h40) begin failures++; $display("FAIL regrant_pending: got %h want 40", d); end
    ack(); cfg_write(6'h04, 32'h0); cycle();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL regrant_second: got %b want 1", IRQ); end
    ack(); cfg_write(6'h04, 32'h0); cycle(); cycle();
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL regrant_done: got %b want 0", IRQ); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0]  a;
    int          r;
    nRst = 1'b1; cycle(); nRst = 1'b0;
    cfg_write(6'h00, 32'($urandom_range(0, 255)));
    cfg_write(6'h01, 32'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) cfg_write(6'(32 + i), $urandom);
    for (int n = 0; n < 600; n++) begin
      irqIn  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      IRQAck = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 11);
      cfgWrEn = (r < 7); cfgWrData = $urandom;
      case (r)
        0: cfgAddr = 6'h02;
        1, 2, 3: cfgAddr = 6'h04;
        4: cfgAddr = 6'h00;
        5: cfgAddr = 6'h01;
        6: cfgAddr = 6'($urandom_range(32, 63));
        default: cfgAddr = 6'h00;
      endcase
      cycle();
      cfgWrEn = 1'b0; IRQAck = 1'b0;
      checks++; if (IRQ !== m_irq) begin failures++; $display("FAIL rand_irq@%0d: got %b want %b", n, IRQ, m_irq); end
      checks++; if (IRQn !== m_irqn) begin failures++; $display("FAIL rand_irqn@%0d: got %h want %h", n, IRQn, m_irqn); end
      a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 4)) : 6'($urandom);
      cfg_read(a, d);
      checks++; if (d !== model_read(a)) begin failures++; $display("FAIL rand_read%h@%0d: got %h want %h", a, n, d, model_read(a)); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    nRst = 1'b1; irqIn = 8'h00; cfgWrEn = 1'b0; cfgAddr = 6'h00; cfgWrData = 32'd0; IRQAck = 1'b0;
    cycle(); cycle();
    nRst = 1'b0;
    test_reset();
    test_single_edge();
    test_priority();
    test_level();
    test_mask_w1c();
    test_collision();
    test_regrant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
